// File: rtl/vc_arbiter.sv
// vc_arbiter: merges the per-VC flit streams of one router input port into a
// single registered flit stream. VCs are granted round-robin on head flits and
// then hold the output (wormhole lock) until their tail flit is accepted.
//
// Handshake: a transfer on any interface happens in a cycle where valid and
// ready are both high at the rising edge. in_ready never depends on in_flit,
// and out_* hold steady while out_valid is high and out_ready is low.
module vc_arbiter #(
   parameter int N_VIRT_CHN = 2,
   parameter int FLIT_WIDTH = 34,
   parameter int VC_W       = $clog2(N_VIRT_CHN)
) (
   input  logic                             clk,
   input  logic                             arst,
   input  logic [N_VIRT_CHN-1:0]            in_valid,
   output logic [N_VIRT_CHN-1:0]            in_ready,
   input  logic [N_VIRT_CHN*FLIT_WIDTH-1:0] in_flit,
   input  logic [N_VIRT_CHN-1:0]            in_head,
   input  logic [N_VIRT_CHN-1:0]            in_tail,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [FLIT_WIDTH-1:0]            out_flit,
   output logic                             out_head,
   output logic                             out_tail,
   output logic [VC_W-1:0]                  out_vc_id,
   output logic                             locked
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t                state;
   logic [VC_W-1:0]       rr_ptr;
   logic [VC_W-1:0]       lock_vc;

   logic                  slot_free;
   logic [N_VIRT_CHN-1:0] grant;
   logic [VC_W-1:0]       grant_idx;
   logic [VC_W-1:0]       cand;
   logic                  found;
   logic                  xfer;
   logic [FLIT_WIDTH-1:0] sel_flit;
   logic                  sel_head;
   logic                  sel_tail;

   // Successor of a VC index with wrap from N_VIRT_CHN-1 back to 0.
   function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] v);
      if (int'(v) == N_VIRT_CHN - 1) begin
         return '0;
      end
      return v + 1'b1;
   endfunction

   // The output register can take a new flit when empty or being drained.
   assign slot_free = !out_valid || out_ready;

   // Grant selection: locked VC owns the slot, otherwise first head from rr_ptr.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand      = '0;
      found     = 1'b0;
      if (arst && slot_free) begin
         if (state == S_LOCKED) begin
            grant[lock_vc] = 1'b1;
            grant_idx      = lock_vc;
         end else begin
            for (int k = 0; k < N_VIRT_CHN; k++) begin
               cand = VC_W'((int'(rr_ptr) + k) % N_VIRT_CHN);
               if (!found && in_valid[cand] && in_head[cand]) begin
                  found       = 1'b1;
                  grant[cand] = 1'b1;
                  grant_idx   = cand;
               end
            end
         end
      end
   end

   assign in_ready = grant;
   assign xfer     = |(in_valid & grant);
   assign sel_flit = in_flit[grant_idx*FLIT_WIDTH +: FLIT_WIDTH];
   assign sel_head = in_head[grant_idx];
   assign sel_tail = in_tail[grant_idx];
   assign locked   = (state == S_LOCKED);

   // Output register plus lock/round-robin state, advanced on accepted flits.
   always_ff @(posedge clk) begin
      if (!arst) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         lock_vc   <= '0;
         out_valid <= 1'b0;
         out_flit  <= '0;
         out_head  <= 1'b0;
         out_tail  <= 1'b0;
         out_vc_id <= '0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_flit  <= sel_flit;
            out_head  <= sel_head;
            out_tail  <= sel_tail;
            out_vc_id <= grant_idx;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               // Only head flits are granted here; a single-flit packet
               // releases the slot at once and moves the pointer on.
               if (xfer) begin
                  if (sel_tail) begin
                     rr_ptr <= next_vc(grant_idx);
                  end else begin
                     state   <= S_LOCKED;
                     lock_vc <= grant_idx;
                  end
               end
            end
            S_LOCKED: begin
               // A stray head flit inside the packet passes through; only
               // the tail ends the lock.
               if (xfer && sel_tail) begin
                  state  <= S_IDLE;
                  rr_ptr <= next_vc(lock_vc);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: directed vector table, hand-written multi-cycle sequences and
// randomized packet traffic for vc_arbiter (N_VIRT_CHN = 2, FLIT_WIDTH = 34).
module tb_vc_arbiter;

   localparam int N  = 2;
   localparam int FW = 34;
   localparam int VW = 1;

   logic            clk = 1'b0;
   logic            arst = 1'b0;
   logic [N-1:0]    in_valid = '0;
   logic [N-1:0]    in_ready;
   logic [N*FW-1:0] in_flit = '0;
   logic [N-1:0]    in_head = '0;
   logic [N-1:0]    in_tail = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [FW-1:0]   out_flit;
   logic            out_head;
   logic            out_tail;
   logic [VW-1:0]   out_vc_id;
   logic            locked;

   int vectors     = 0;
   int miscompares = 0;

   // clock
   always #5 clk = ~clk;

   vc_arbiter #(.N_VIRT_CHN(N), .FLIT_WIDTH(FW), .VC_W(VW)) dut (
      .clk       (clk),
      .arst      (arst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_flit   (in_flit),
      .in_head   (in_head),
      .in_tail   (in_tail),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_flit  (out_flit),
      .out_head  (out_head),
      .out_tail  (out_tail),
      .out_vc_id (out_vc_id),
      .locked    (locked)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // owner < 0 means no VC holds the output.
   int            m_owner;
   int            m_rr;
   logic          m_ov;
   logic          m_oh;
   logic          m_ot;
   logic [FW-1:0] m_of;
   int            m_ovc;
   logic [N-1:0]  last_xfer;

   task automatic model_reset();
      m_owner = -1;
      m_rr    = 0;
      m_ov    = 1'b0;
      m_oh    = 1'b0;
      m_ot    = 1'b0;
      m_of    = '0;
      m_ovc   = 0;
   endtask

   function automatic logic [N-1:0] model_ready();
      logic [N-1:0] r;
      int v;
      r = '0;
      if (!arst) return r;
      if (m_ov && !out_ready) return r;
      if (m_owner >= 0) begin
         r[m_owner] = 1'b1;
         return r;
      end
      for (int k = 0; k < N; k++) begin
         v = (m_rr + k) % N;
         if (in_valid[v] && in_head[v]) begin
            r[v] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   task automatic model_step(input logic [N-1:0] r);
      int v;
      v = -1;
      if (!arst) begin
         model_reset();
         return;
      end
      for (int k = 0; k < N; k++) if (r[k] && in_valid[k]) v = k;
      if (v >= 0) begin
         m_ov  = 1'b1;
         m_of  = in_flit[v*FW +: FW];
         m_oh  = in_head[v];
         m_ot  = in_tail[v];
         m_ovc = v;
         if (m_owner < 0) begin
            if (in_tail[v]) m_rr = (v + 1) % N;
            else            m_owner = v;
         end else if (in_tail[v]) begin
            m_rr    = (m_owner + 1) % N;
            m_owner = -1;
         end
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
   endtask

   // One clock cycle checked against the model; called just after a falling
   // edge with the inputs already driven, returns on the next falling edge.
   task automatic cyc();
      logic [N-1:0] er;
      #1;
      er = model_ready();
      check("in_ready", in_ready, er);
      @(posedge clk);
      last_xfer = er & in_valid;
      model_step(er);
      @(negedge clk);
      check("out_valid", out_valid, m_ov);
      check("out_flit", out_flit, m_of);
      check("out_head", out_head, m_oh);
      check("out_tail", out_tail, m_ot);
      check("out_vc_id", out_vc_id, m_ovc);
      check("locked", locked, m_owner >= 0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic [1:0] v, input logic [1:0] h, input logic [1:0] t,
                         input logic [FW-1:0] d0, input logic [FW-1:0] d1);
      in_valid = v;
      in_head  = h;
      in_tail  = t;
      in_flit  = {d1, d0};
   endtask

   task automatic do_reset();
      arst      = 1'b0;
      out_ready = 1'b1;
      set_in(2'b00, 2'b00, 2'b00, '0, '0);
      cyc();
      arst = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0] valid;
      logic [1:0] head;
      logic [1:0] tail;
      logic       ordy;
      logic [1:0] exp_ready;
      logic       exp_ov;
      logic       exp_vc;
      logic       exp_lock;
   } vec_t;

   vec_t tbl[15];

   // random traffic generator state
   int            plen[N];
   int            ppos[N];
   logic [FW-1:0] pdat[N];

   initial begin
      logic [FW-1:0] exp_flit;
      logic [FW-1:0] d0;
      logic [FW-1:0] d1;
      logic [1:0]    v;
      logic [1:0]    h;
      logic [1:0]    t;

      model_reset();
      last_xfer = '0;

      //             valid  head   tail   ordy  ready  ov    vc    lock
      tbl[0]  = '{2'b11, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{2'b11, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{2'b11, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{2'b11, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{2'b10, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{2'b11, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{2'b11, 2'b10, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{2'b11, 2'b10, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{2'b11, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{2'b01, 2'b01, 2'b01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
      tbl[13] = '{2'b01, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};

      @(negedge clk);

      // reset held 3 cycles with every VC offering a head
      arst = 1'b0;
      set_in(2'b11, 2'b11, 2'b11, 34'h3_0000_0001, 34'h3_0000_0002);
      repeat (3) begin
         cyc();
         check("rst_ready", in_ready, 2'b00);
         check("rst_out_valid", out_valid, 1'b0);
         check("rst_out_flit", out_flit, '0);
      end
      arst = 1'b1;
      #1;
      check("first_grant", in_ready, 2'b01);
      cyc();
      check("first_vc", out_vc_id, 1'b0);

      // directed table from a fresh reset
      do_reset();
      exp_flit = '0;
      for (int i = 0; i < 15; i++) begin
         d0 = 34'h100 + FW'(i);
         d1 = 34'h200 + FW'(i);
         set_in(tbl[i].valid, tbl[i].head, tbl[i].tail, d0, d1);
         out_ready = tbl[i].ordy;
         #1;
         check("tbl_ready", in_ready, tbl[i].exp_ready);
         if ((tbl[i].exp_ready & tbl[i].valid) == 2'b01) exp_flit = d0;
         if ((tbl[i].exp_ready & tbl[i].valid) == 2'b10) exp_flit = d1;
         @(posedge clk);
         @(negedge clk);
         check("tbl_out_valid", out_valid, tbl[i].exp_ov);
         check("tbl_vc_id", out_vc_id, tbl[i].exp_vc);
         check("tbl_locked", locked, tbl[i].exp_lock);
         if (tbl[i].exp_ov) check("tbl_flit", out_flit, exp_flit);
      end

      // wormhole: VC0 four-flit packet while VC1 keeps a head waiting
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(2'b11, {1'b1, i == 0}, {1'b1, i == 3}, 34'hA0 + FW'(i), 34'hB0);
         cyc();
         check("worm_vc", out_vc_id, 1'b0);
         check("worm_flit", out_flit, 34'hA0 + FW'(i));
         check("worm_lock", locked, i < 3);
      end
      set_in(2'b10, 2'b10, 2'b10, '0, 34'hB0);
      cyc();
      check("worm_next_vc", out_vc_id, 1'b1);
      check("worm_next_flit", out_flit, 34'hB0);

      // backpressure mid-packet
      do_reset();
      set_in(2'b01, 2'b01, 2'b00, 34'hC0, '0);
      cyc();
      set_in(2'b01, 2'b00, 2'b00, 34'hC1, '0);
      cyc();
      out_ready = 1'b0;
      set_in(2'b01, 2'b00, 2'b00, 34'hC2, '0);
      repeat (5) begin
         cyc();
         check("bp_ready", in_ready, 2'b00);
         check("bp_flit", out_flit, 34'hC1);
         check("bp_valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      cyc();
      check("bp_resume_c2", out_flit, 34'hC2);
      set_in(2'b01, 2'b00, 2'b01, 34'hC3, '0);
      cyc();
      check("bp_resume_c3", out_flit, 34'hC3);
      set_in(2'b00, 2'b00, 2'b00, '0, '0);
      cyc();
      check("bp_drained", out_valid, 1'b0);

      // body flit on an unlocked VC is never granted
      do_reset();
      set_in(2'b10, 2'b00, 2'b00, '0, 34'hD0);
      repeat (4) begin
         cyc();
         check("nohead_ready", in_ready, 2'b00);
         check("nohead_valid", out_valid, 1'b0);
      end

      // reset in the middle of a packet
      do_reset();
      set_in(2'b01, 2'b01, 2'b00, 34'hE0, '0);
      cyc();
      set_in(2'b01, 2'b00, 2'b00, 34'hE1, '0);
      cyc();
      check("mid_locked_before", locked, 1'b1);
      arst = 1'b0;
      cyc();
      check("mid_locked", locked, 1'b0);
      check("mid_out_valid", out_valid, 1'b0);
      check("mid_out_flit", out_flit, '0);
      arst = 1'b1;
      set_in(2'b11, 2'b10, 2'b10, 34'hE2, 34'hF0);
      #1;
      check("mid_vc1_grant", in_ready, 2'b10);
      cyc();
      check("mid_vc1_out", out_vc_id, 1'b1);
      check("mid_vc1_flit", out_flit, 34'hF0);

      // randomized packet traffic against the model
      do_reset();
      for (int k = 0; k < N; k++) begin
         plen[k] = 0;
         ppos[k] = 0;
         pdat[k] = '0;
      end
      for (int c = 0; c < 3000; c++) begin
         arst = ($urandom_range(0, 199) != 0);
         for (int k = 0; k < N; k++) begin
            if (ppos[k] >= plen[k]) begin
               plen[k] = $urandom_range(1, 4);
               ppos[k] = 0;
               pdat[k] = {2'($urandom_range(0, 3)), $urandom()};
            end
            v[k] = ($urandom_range(0, 3) != 0);
            h[k] = (ppos[k] == 0);
            t[k] = (ppos[k] == plen[k] - 1);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         set_in(v, h, t, pdat[0], pdat[1]);
         cyc();
         for (int k = 0; k < N; k++) begin
            if (!arst) begin
               ppos[k] = plen[k];
            end else if (last_xfer[k]) begin
               ppos[k]++;
               pdat[k] = {2'($urandom_range(0, 3)), $urandom()};
            end
         end
      end
      arst = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
